// File: rtl/i4001_rom_if.sv
// i4001_rom_if: shared MCS-4 data bus and control lines as seen by one 4001 ROM.
// Latency: none, plain wires.
// Backpressure: none; the bus is phase-timed, so the driver with dbus_oe high wins.
// Signals: sync/cm_rom from the CPU, dbus_in is the resolved bus nibble,
//          dbus_out/dbus_oe are what the ROM chip puts on the bus.
interface i4001_rom_if;
  logic       sync;
  logic       cm_rom;
  logic [3:0] dbus_in;
  logic [3:0] dbus_out;
  logic       dbus_oe;

  // CPU / bus-resolver side
  modport master (
    output sync, cm_rom, dbus_in,
    input  dbus_out, dbus_oe
  );

  // ROM chip side
  modport slave (
    input  sync, cm_rom, dbus_in,
    output dbus_out, dbus_oe
  );
endinterface

// File: rtl/i4001_rom.sv
// i4001_rom: one 4001 chip - 256x8 program ROM, 4-bit I/O port, SRC/WRR/RDR decode.
// Latency: bus drive is registered on the edge entering M1/M2 (fetch) or X2 (RDR).
// Backpressure: none; timing is fixed by the 8-phase cycle started by sync.
// Ports: clk, rst (async active-low), bus (slave modport of i4001_rom_if),
//        io_in/io_out (port pins), prog_we/prog_addr/prog_data (host ROM loader).
module i4001_rom #(
  parameter logic [3:0] CHIP_ID = 4'h0,
  parameter logic [3:0] IO_MASK = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  i4001_rom_if.slave bus,
  input  logic [3:0] io_in,
  output logic [3:0] io_out,
  input  logic       prog_we,
  input  logic [7:0] prog_addr,
  input  logic [7:0] prog_data
);

  typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} phase_t;

  // IDLE is represented as running == 0; phase itself keeps the 3-bit cycle position.
  phase_t     phase;
  logic       running;

  logic [7:0] mem [256];
  logic [7:0] rom_rd;
  logic [7:0] addr;
  logic [3:0] rom_lo;     // OPA nibble of the fetched word, driven in M2
  logic [7:0] instr;      // snooped instruction word
  logic       rom_sel;
  logic       src_sel;
  logic       io_cmd;
  logic       dw_pend;    // current word is the first of a double-word instruction
  logic       second;     // current cycle carries the second word of a double-word instruction
  logic [3:0] dout;
  logic       doe;

  logic       a3_hit;
  logic       dw_op;
  logic       src_hit;
  logic       wrr_hit;
  logic       rdr_hit;
  logic [3:0] rdr_val;

  // ROM array has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
  end

  // Read-before-write: a write on the same edge is not visible here.
  assign rom_rd = mem[addr];

  always_comb begin
    a3_hit  = bus.cm_rom && (bus.dbus_in == CHIP_ID);
    // Evaluated in M2: OPR already in instr[7:4], OPA on the bus.
    // JCN, FIM, JUN, JMS, ISZ carry a second word in the next cycle.
    dw_op   = (instr[7:4] == 4'h1) ||
              ((instr[7:4] == 4'h2) && !bus.dbus_in[0]) ||
              (instr[7:4] == 4'h4) ||
              (instr[7:4] == 4'h5) ||
              (instr[7:4] == 4'h7);
    src_hit = (instr[7:4] == 4'h2) && instr[0] && bus.cm_rom;
    wrr_hit = io_cmd && src_sel && (instr == 8'hE2);
    rdr_hit = io_cmd && src_sel && (instr == 8'hEA);
    // Output bits read back the latch, input bits read the pins.
    rdr_val = (io_in & ~IO_MASK) | (io_out & IO_MASK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase   <= A1;
      running <= 1'b0;
      addr    <= 8'h00;
      rom_lo  <= 4'h0;
      instr   <= 8'h00;
      rom_sel <= 1'b0;
      src_sel <= 1'b0;
      io_cmd  <= 1'b0;
      dw_pend <= 1'b0;
      second  <= 1'b0;
      io_out  <= 4'h0;
      dout    <= 4'h0;
      doe     <= 1'b0;
    end else begin
      // Drive lasts exactly one phase unless re-armed below.
      dout <= 4'h0;
      doe  <= 1'b0;
      if (running) begin
        phase <= phase_t'(phase + 3'd1);
        unique case (phase)
          A1: addr[3:0] <= bus.dbus_in;
          A2: addr[7:4] <= bus.dbus_in;
          A3: begin
            rom_sel <= a3_hit;
            rom_lo  <= rom_rd[3:0];
            // This edge enters M1, so the OPR nibble goes out now.
            if (a3_hit) begin
              dout <= rom_rd[7:4];
              doe  <= 1'b1;
            end
          end
          M1: begin
            instr[7:4] <= bus.dbus_in;
            if (rom_sel) begin
              dout <= rom_lo;
              doe  <= 1'b1;
            end
          end
          M2: begin
            instr[3:0] <= bus.dbus_in;
            io_cmd     <= (instr[7:4] == 4'hE) && bus.cm_rom && !second;
            dw_pend    <= !second && dw_op;
          end
          X1: begin
            if (rdr_hit) begin
              dout <= rdr_val;
              doe  <= 1'b1;
            end
          end
          X2: begin
            if (src_hit) src_sel <= (bus.dbus_in == CHIP_ID);
            if (wrr_hit) io_out  <= bus.dbus_in & IO_MASK;
          end
          X3: second <= dw_pend;
        endcase
      end
      // sync always realigns to A1; an early sync cancels whatever drive was armed.
      if (bus.sync) begin
        phase   <= A1;
        running <= 1'b1;
        dout    <= 4'h0;
        doe     <= 1'b0;
      end
    end
  end

  assign bus.dbus_out = dout;
  assign bus.dbus_oe  = doe;

endmodule

// File: tb/tb_i4001_rom.sv
// tb_i4001_rom: directed table-driven bench for i4001_rom (CHIP_ID=2, IO_MASK=3).
// Latency: checks drive one clk after the phase-entering edge.
// Backpressure: n/a; the bench plays the 4004 CPU and resolves the shared bus.
module tb_i4001_rom;

  localparam logic [3:0] CHIP = 4'h2;

  logic       clk;
  logic       rst;
  logic [3:0] io_in;
  logic [3:0] io_out;
  logic       prog_we;
  logic [7:0] prog_addr;
  logic [7:0] prog_data;
  logic [3:0] cpu_drv;

  int checks = 0;
  int errors = 0;

  i4001_rom_if bus();

  // Bus resolution: the ROM wins when it drives.
  assign bus.dbus_in = bus.dbus_oe ? bus.dbus_out : cpu_drv;

  i4001_rom #(.CHIP_ID(CHIP), .IO_MASK(4'h3)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .io_in     (io_in),
    .io_out    (io_out),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    string      name;
    logic [3:0] a1, a2, a3;
    logic       cm_a3;
    logic [3:0] m1, m2;
    logic       cm_m2;
    logic [3:0] x2;
    logic       cm_x2;
    logic [3:0] io_in;
    logic       pw;
    logic [7:0] pa, pd;
    logic [4:0] e_m1, e_m2, e_x2;   // {oe, nibble} expected in M1, M2, X2
    logic [3:0] e_io;               // io_out after the cycle
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic c, input logic [3:0] d);
    @(negedge clk);
    bus.sync   = s;
    bus.cm_rom = c;
    cpu_drv    = d;
  endtask

  task automatic prog(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // One full instruction cycle A1..X3; sync raised in X3 to start the next.
  task automatic run_vec(input vec_t v);
    logic [4:0] e;
    io_in = v.io_in;
    for (int p = 0; p < 8; p++) begin
      @(negedge clk);
      case (p)
        3:       e = v.e_m1;
        4:       e = v.e_m2;
        6:       e = v.e_x2;
        default: e = 5'h00;
      endcase
      check($sformatf("%s.ph%0d", v.name, p), {3'b0, bus.dbus_oe, bus.dbus_out}, {3'b0, e});
      bus.sync   = (p == 7);
      bus.cm_rom = 1'b0;
      cpu_drv    = 4'h0;
      prog_we    = 1'b0;
      case (p)
        0: cpu_drv = v.a1;
        1: cpu_drv = v.a2;
        2: begin
          cpu_drv = v.a3; bus.cm_rom = v.cm_a3;
          prog_we = v.pw; prog_addr = v.pa; prog_data = v.pd;
        end
        3: cpu_drv = v.m1;
        4: begin cpu_drv = v.m2; bus.cm_rom = v.cm_m2; end
        6: begin cpu_drv = v.x2; bus.cm_rom = v.cm_x2; end
        default: ;
      endcase
    end
    check({v.name, ".io_out"}, {4'h0, io_out}, {4'h0, v.e_io});
  endtask

  initial begin
    logic any_oe;
    //           name            a1   a2   a3   cmA  m1    m2    cmM x2    cmX io_in pw  pa     pd     e_m1   e_m2   e_x2   e_io
    vecs[0]  = '{"fetch_sel",    0,   0,   2,   1,   0,    0,    0,  0,    0,  0,    0,  8'h00, 8'h00, 5'h1D, 5'h15, 5'h00, 4'h0};
    vecs[1]  = '{"cm_low",       0,   0,   2,   0,   0,    0,    0,  0,    0,  0,    0,  8'h00, 8'h00, 5'h00, 5'h00, 5'h00, 4'h0};
    vecs[2]  = '{"src_self",     0,   0,   3,   1,   2,    1,    0,  2,    1,  0,    0,  8'h00, 8'h00, 5'h00, 5'h00, 5'h00, 4'h0};
    vecs[3]  = '{"wrr_snoop",    0,   0,   3,   1,   4'hE, 2,    1,  4'hF, 0,  0,    0,  8'h00, 8'h00, 5'h00, 5'h00, 5'h00, 4'h3};
    vecs[4]  = '{"rdr",          0,   0,   3,   1,   4'hE, 4'hA, 1,  0,    0,  4'hC, 0,  8'h00, 8'h00, 5'h00, 5'h00, 5'h1F, 4'h3};
    vecs[5]  = '{"wrr_no_cm",    0,   0,   3,   1,   4'hE, 2,    0,  0,    0,  0,    0,  8'h00, 8'h00, 5'h00, 5'h00, 5'h00, 4'h3};
    vecs[6]  = '{"other_e",      0,   0,   3,   1,   4'hE, 4,    1,  0,    0,  0,    0,  8'h00, 8'h00, 5'h00, 5'h00, 5'h00, 4'h3};
    vecs[7]  = '{"src_other",    0,   0,   3,   1,   2,    1,    0,  5,    1,  0,    0,  8'h00, 8'h00, 5'h00, 5'h00, 5'h00, 4'h3};
    vecs[8]  = '{"rdr_other",    0,   0,   3,   1,   4'hE, 4'hA, 1,  0,    0,  4'hC, 0,  8'h00, 8'h00, 5'h00, 5'h00, 5'h00, 4'h3};
    vecs[9]  = '{"wrr_other",    0,   0,   3,   1,   4'hE, 2,    1,  0,    0,  0,    0,  8'h00, 8'h00, 5'h00, 5'h00, 5'h00, 4'h3};
    vecs[10] = '{"src_self2",    0,   0,   3,   1,   2,    1,    0,  2,    1,  0,    0,  8'h00, 8'h00, 5'h00, 5'h00, 5'h00, 4'h3};
    vecs[11] = '{"wrr_mask",     0,   0,   3,   1,   4'hE, 2,    1,  4'hC, 0,  0,    0,  8'h00, 8'h00, 5'h00, 5'h00, 5'h00, 4'h0};
    vecs[12] = '{"jun_word1",    0,   0,   3,   1,   4,    0,    0,  0,    0,  0,    0,  8'h00, 8'h00, 5'h00, 5'h00, 5'h00, 4'h0};
    vecs[13] = '{"jun_word2",    0,   0,   3,   1,   4'hE, 2,    1,  4'hF, 0,  0,    0,  8'h00, 8'h00, 5'h00, 5'h00, 5'h00, 4'h0};
    vecs[14] = '{"wrr_after_dw", 0,   0,   3,   1,   4'hE, 2,    1,  1,    0,  0,    0,  8'h00, 8'h00, 5'h00, 5'h00, 5'h00, 4'h1};
    vecs[15] = '{"fetch_21",     1,   2,   2,   1,   0,    0,    0,  0,    0,  0,    0,  8'h00, 8'h00, 5'h16, 5'h1B, 5'h00, 4'h1};
    vecs[16] = '{"prog_in_a3",   2,   1,   2,   1,   0,    0,    0,  0,    0,  0,    1,  8'h12, 8'h3C, 5'h19, 5'h1A, 5'h00, 4'h1};
    vecs[17] = '{"fetch_new",    2,   1,   2,   1,   0,    0,    0,  0,    0,  0,    0,  8'h00, 8'h00, 5'h13, 5'h1C, 5'h00, 4'h1};

    rst = 1'b0;
    bus.sync = 1'b0; bus.cm_rom = 1'b0; cpu_drv = 4'h0;
    io_in = 4'h0; prog_we = 1'b0; prog_addr = 8'h00; prog_data = 8'h00;

    // ROM loads while held in reset; contents must survive.
    prog(8'h00, 8'hD5);
    prog(8'h12, 8'h9A);
    prog(8'h21, 8'h6B);

    check("rst_oe",     {7'h0, bus.dbus_oe}, 8'h00);
    check("rst_dout",   {4'h0, bus.dbus_out}, 8'h00);
    check("rst_io_out", {4'h0, io_out}, 8'h00);

    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1'b0, 4'h0);

    for (int i = 0; i < 18; i++) run_vec(vecs[i]);

    // Early sync in X1 of an RDR cycle: drive aborted, A1 restarts immediately.
    io_in = 4'hC;
    step(0, 0, 4'h0);
    step(0, 0, 4'h0);
    step(0, 1, 4'h3);
    step(0, 0, 4'hE);
    step(0, 1, 4'hA);
    step(1, 0, 4'h0);
    @(posedge clk); #1;
    check("early_sync_abort", {7'h0, bus.dbus_oe}, 8'h00);
    step(0, 0, 4'h1);
    step(0, 0, 4'h2);
    step(0, 1, CHIP);
    @(posedge clk); #1;
    check("early_sync_m1", {3'b0, bus.dbus_oe, bus.dbus_out}, 8'h16);
    step(0, 0, 4'h0);
    @(posedge clk); #1;
    check("early_sync_m2", {3'b0, bus.dbus_oe, bus.dbus_out}, 8'h1B);
    step(0, 0, 4'h0);
    step(0, 0, 4'h0);
    step(0, 0, 4'h0);
    step(1, 0, 4'h0);

    // Reset in M1 of a selected fetch.
    step(0, 0, 4'h0);
    step(0, 0, 4'h0);
    step(0, 1, CHIP);
    @(posedge clk); #1;
    check("pre_rst_m1", {3'b0, bus.dbus_oe, bus.dbus_out}, 8'h1D);
    #2 rst = 1'b0;
    #1;
    check("async_rst_oe",   {3'b0, bus.dbus_oe, bus.dbus_out}, 8'h00);
    check("async_rst_io",   {4'h0, io_out}, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    any_oe = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(0, 1, CHIP);
      @(posedge clk); #1;
      any_oe = any_oe | bus.dbus_oe;
    end
    check("no_drive_before_sync", {7'h0, any_oe}, 8'h00);
    step(1, 0, 4'h0);
    run_vec(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i4001_rom.md
Name: i4001_rom

Overview:
- Models one MCS-4 4001 ROM chip: 256x8 program ROM plus a 4-bit I/O port.
- Sits downstream of the 4004 CPU on the shared 4-bit data bus.
- Follows the 8-phase instruction cycle from `sync`: latches the 12-bit address (A1..A3), returns the OPR/OPA nibbles in M1/M2, and executes SRC/WRR/RDR for its own chip number.
- A host-side programming port loads ROM contents from the PYNQ PS.

Parameters:
- CHIP_ID, 4'h0, chip number compared against address nibble A3 and the SRC high nibble.
- IO_MASK, 4'h0, per-bit port direction; 1 = output, 0 = input.

Ports:
- clk  input  1  system clock; every phase is one clk cycle.
- rst  input  1  asynchronous, active-low reset.
- sync  input  1  from CPU; high during X3, so the next cycle is A1.
- cm_rom  input  1  CPU ROM command line.
- dbus_in  input  4  resolved shared data bus as seen by all devices.
- dbus_out  output  4  nibble this chip drives.
- dbus_oe  output  1  high when dbus_out is valid and must win bus arbitration.
- io_in  input  4  external port input pins.
- io_out  output  4  port output latch; only IO_MASK bits are meaningful, others held 0.
- prog_we  input  1  ROM write strobe.
- prog_addr  input  8  ROM write address.
- prog_data  input  8  ROM write data; [7:4] = OPR, [3:0] = OPA.

Behaviour:

Reset (rst low, async):
- phase = IDLE.
- dbus_out = 0, dbus_oe = 0, io_out = 0.
- Internal state cleared: rom_sel, src_sel, io_cmd, addr, instr.
- ROM array is not cleared.

Phase tracking:
- 3-bit phase register.
- Any posedge with sync = 1 sets phase = A1.
- Otherwise phase advances A1, A2, A3, M1, M2, X1, X2, X3, then wraps to A1.
- From IDLE, phase stays IDLE until the first sync.
- In IDLE, nothing is latched or driven.
- sync seen in a phase other than X3 resynchronises to A1 and aborts any pending drive.

Address and selection:
- A1: addr[3:0] <= dbus_in.
- A2: addr[7:4] <= dbus_in.
- A3: rom_sel <= (cm_rom && dbus_in == CHIP_ID); rom_q <= mem[addr].
  - The read uses the addr completed by the A2 latch.

Instruction fetch (outputs registered, updated on the edge that enters the phase):
- Entering M1: if rom_sel, dbus_out = rom_q[7:4] and dbus_oe = 1.
- Entering M2: if rom_sel, dbus_out = rom_q[3:0] and dbus_oe = 1.
- dbus_oe = 0 in every other phase unless a port read below applies.

Instruction snoop (all chips, selected or not):
- M1: instr[7:4] <= dbus_in.
- M2: instr[3:0] <= dbus_in; io_cmd <= (instr[7:4] == 4'hE && cm_rom).
- The second word of a double-word instruction is also snooped; it never sets io_cmd.

SRC:
- Recognised when instr[7:4] == 4'h2, instr[0] == 1 and cm_rom is high in X2.
- X2: src_sel <= (dbus_in == CHIP_ID).
- src_sel holds until the next SRC or reset.

WRR (instr == 8'hE2, io_cmd, src_sel):
- X2: io_out <= dbus_in & IO_MASK.

RDR (instr == 8'hEA, io_cmd, src_sel):
- Entering X2: dbus_out = (io_in & ~IO_MASK) | (io_out & IO_MASK), dbus_oe = 1.
- io_in is sampled on the X1 edge.

Other 0xE_ opcodes: ignored; no drive, no state change.

Programming port:
- prog_we writes mem[prog_addr] <= prog_data at posedge.
- A same-cycle read in A3 of the same address returns the old data.
- Legal at any time, including mid-cycle.

Reset mid-cycle:
- Outputs drop immediately to 0.
- No drive until the next sync-aligned A1 to A3 sequence completes.

Test Plan:
1. Program mem[0x00] = 8'hD5; reset; sync pulse; bus 0, 0, CHIP_ID with cm_rom high in A3 -> dbus_oe = 1 with dbus_out = 4'hD in M1, 4'h5 in M2; dbus_oe = 0 in X1..X3.
2. Same sequence with A3 nibble = CHIP_ID+1 -> dbus_oe stays 0 for the whole cycle; instr still snoops the bus values.
3. SRC (M1 = 2, M2 = 1, X2 = CHIP_ID, cm_rom high), then WRR (M1 = E, M2 = 2, cm_rom in M2, X2 = 4'hF) with IO_MASK = 4'h3 -> io_out = 4'h3.
4. After step 3, io_in = 4'hC, RDR (E,A) -> in X2 dbus_oe = 1 and dbus_out = 4'hF; with SRC to another chip, no drive and io_out unchanged.
5. Assert rst low during M1 of a selected fetch -> dbus_oe = 0 and dbus_out = 0 asynchronously; no drive until a fresh sync plus a selected A3.
6. prog_we writes 0x12 = 8'h3C while fetching addr 0x12 -> the current fetch returns the old value; the next fetch returns 3, C. An early sync in X1 -> phase restarts at A1.
